alu_issue: RTL and testbench
============================

# alu_issue

Single-issue decode/operand/writeback unit that drives the `alu` block in the CPU. It accepts 32-bit instruction words over a valid/ready handshake and decodes the ALU-class opcodes. It reads operands from an internal 32×32 register file, presents `opcode`/`sub_op_base`/`alu_src1`/`alu_src2` with `enable_execute`, then captures `alu_result`/`alu_overflow` and writes the result back to `rt`.

## Interface
Parameters:
- `REG_COUNT`, 32: register-file depth; fixed by the 5-bit register fields.

Ports:
- `clock`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inst_valid`  in  1  instruction word offered.
- `inst_ready`  out  1  block can accept an instruction.
- `inst_word`  in  32  instruction word.
- `enable_execute`  out  1  ALU operands valid this cycle.
- `opcode`  out  6  to ALU.
- `sub_op_base`  out  5  to ALU.
- `alu_src1`  out  32  to ALU.
- `alu_src2`  out  32  to ALU.
- `alu_result`  in  32  from ALU; combinational.
- `alu_overflow`  in  1  from ALU.
- `wb_valid`  out  1  one-cycle pulse; a register was written.
- `wb_addr`  out  5  register written.
- `wb_data`  out  32  value written.
- `inst_illegal`  out  1  one-cycle pulse; accepted word was dropped.
- `overflow_flag`  out  1  sticky arithmetic overflow.
- `overflow_clear`  in  1  clears `overflow_flag`.
- `rf_dbg_addr`  in  5  debug read address.
- `rf_dbg_data`  out  32  combinational read `R[rf_dbg_addr]`.

## Operation
- Field layout:
  - `[31]` must be 0.
  - `opcode=[30:25]`, `rt=[24:20]`, `ra=[19:15]`, `rb=[14:10]`, `sub=[4:0]`.
  - `imm15=[14:0]`; `imm5=[14:10]`.
- Supported opcodes:
  - `TY_BASE` 6'b100000.
  - `ADDI` 6'b101000, `SUBRI` 6'b101001, `ANDI` 6'b101010, `XORI` 6'b101011, `ORI` 6'b101100.
- Supported `TY_BASE` sub-ops:
  - `ADD` 0, `SUB` 1, `AND` 2, `XOR` 3, `OR` 4.
  - `SLLI` 8, `SRLI` 9, `ROTRI` 11, `SLL` 12, `SRL` 13.
- Illegal instructions (`inst_illegal` pulse, no ALU cycle, no write):
  - `[31]=1`.
  - Any other opcode, including `LWI`/`SWI`/`TY_LS`, which are handled by the memory path.
  - Any other sub-op.
- Operand formation:
  - `alu_src1 = R[ra]` for every supported instruction.
  - `alu_src2` for `ADD`/`SUB`/`AND`/`XOR`/`OR`: `R[rb]`.
  - `alu_src2` for `SLL`/`SRL`: `{27'b0, R[rb][4:0]}`.
  - `alu_src2` for `SLLI`/`SRLI`/`ROTRI`: `{27'b0, imm5}`.
  - `alu_src2` for `ADDI`/`SUBRI`: `imm15` sign-extended.
  - `alu_src2` for `ANDI`/`ORI`/`XORI`: `imm15` zero-extended.
- FSM states:
  - `IDLE`: `inst_ready=1`. On handshake, decode. Legal → `EXEC`; illegal → pulse `inst_illegal`, stay in `IDLE`.
  - `EXEC`: `enable_execute=1`. At the end edge, write `alu_result` to `R[rt]` and latch `wb_addr`/`wb_data` → `WB`.
  - `WB`: `wb_valid=1` → `IDLE`.
- `overflow_flag` is set in `EXEC` when `alu_overflow=1` and the instruction is `ADD`, `SUB`, `ADDI` or `SUBRI`. `overflow_clear` clears it; if set and clear occur in the same cycle, set wins.
- `opcode`, `sub_op_base`, `alu_src1` and `alu_src2` are registered and hold their last values outside `EXEC`; they never go X.
- `R0` is an ordinary writable register.

## Timing
- Reset values: all outputs 0 except `inst_ready=1`; all registers 0; state `IDLE`.
- Handshake is sampled at the rising edge, cycle N.
- `enable_execute` is high in cycle N+1.
- The register-file write occurs at the N+2 edge; `wb_valid` is high in cycle N+2.
- Next accept is possible at the N+3 edge, giving a throughput of 1 instruction per 3 cycles.
- `inst_ready=0` in `EXEC` and `WB`; `inst_valid` offered there is ignored and must be held by the source.
- An illegal word is consumed at edge N; `inst_illegal` is high in cycle N+1, and the block is ready again in cycle N+1.
- Read-after-write: an instruction accepted in the `IDLE` cycle after `WB` sees the written value. No bypass is required.
- Reset asserted mid-instruction: immediately returns to `IDLE` with reset values. The in-flight instruction is discarded and no write occurs.

## Structure
- Opcode and sub-op constants come from the shared `def_opcode.v`; no new values are added.
- FSM state encodings are local to this block.
- Natural sub-module: `reg_file_32x32` — one synchronous write port, two combinational read ports plus the debug read port, asynchronous active-low clear.

## Test plan
- Write, extend, add:
  - `0x50100005` (`ADDI r1,r0,5`) → `r1=5`.
  - `0x50207FFF` → `r2=0xFFFFFFFF`.
  - `0x40308800` (`ADD r3,r1,r2`) → `wb_addr=3`, `wb_data=4`, `overflow_flag=0`.
- Overflow:
  - `0x50607FFF`, then `0x40630409` (`SRLI r6,r6,1`) → `r6=0x7FFFFFFF`.
  - `0x40731800` (`ADD r7,r6,r6`) → `r7=0xFFFFFFFE`, `overflow_flag=1`.
  - `overflow_clear` pulse → `overflow_flag=0`.
- Zero-extension: with `r2=0xFFFFFFFF`, `0x54817FFF` (`ANDI r8,r2,0x7FFF`) → `r8=0x00007FFF`.
- Illegal word: `0x80000000` → `inst_illegal` high for exactly 1 cycle; no `wb_valid`; `inst_ready` high in the next cycle.
- Timing and back-pressure: `inst_valid` held high across back-to-back legal words → accepts 3 cycles apart; `enable_execute` high exactly 1 cycle per instruction.
- Reset during `EXEC` of `0x50100005` → no write; `r1` reads 0 via `rf_dbg`; state `IDLE`; `inst_ready=1`.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared decode constants, FSM states and the instruction decoder for alu_issue.
package alu_issue_pkg;

  // Major opcodes handled on the ALU path
  localparam logic [5:0] OP_TY_BASE = 6'b100000;
  localparam logic [5:0] OP_ADDI    = 6'b101000;
  localparam logic [5:0] OP_SUBRI   = 6'b101001;
  localparam logic [5:0] OP_ANDI    = 6'b101010;
  localparam logic [5:0] OP_XORI    = 6'b101011;
  localparam logic [5:0] OP_ORI     = 6'b101100;

  // TY_BASE sub-operations
  localparam logic [4:0] SUB_ADD   = 5'd0;
  localparam logic [4:0] SUB_SUB   = 5'd1;
  localparam logic [4:0] SUB_AND   = 5'd2;
  localparam logic [4:0] SUB_XOR   = 5'd3;
  localparam logic [4:0] SUB_OR    = 5'd4;
  localparam logic [4:0] SUB_SLLI  = 5'd8;
  localparam logic [4:0] SUB_SRLI  = 5'd9;
  localparam logic [4:0] SUB_ROTRI = 5'd11;
  localparam logic [4:0] SUB_SLL   = 5'd12;
  localparam logic [4:0] SUB_SRL   = 5'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // How the second ALU operand is built from the word and the register file
  typedef enum logic [2:0] {
    SRC2_RB     = 3'd0,  // R[rb]
    SRC2_SHAMT  = 3'd1,  // R[rb][4:0], zero-extended
    SRC2_IMM5   = 3'd2,  // imm5, zero-extended
    SRC2_SIMM15 = 3'd3,  // imm15, sign-extended
    SRC2_ZIMM15 = 3'd4   // imm15, zero-extended
  } src2_sel_t;

  typedef struct packed {
    logic      legal;  // word is an ALU-class instruction we execute
    logic      arith;  // result may raise the sticky overflow flag
    src2_sel_t src2_sel;
  } decode_t;

  // Classify an instruction word; anything not listed is illegal here
  function automatic decode_t decode_inst(input logic [31:0] word);
    decode_t d;
    d.legal    = 1'b0;
    d.arith    = 1'b0;
    d.src2_sel = SRC2_RB;
    if (!word[31]) begin
      case (word[30:25])
        OP_TY_BASE: begin
          case (word[4:0])
            SUB_ADD, SUB_SUB: begin
              d.legal = 1'b1;
              d.arith = 1'b1;
            end
            SUB_AND, SUB_XOR, SUB_OR: d.legal = 1'b1;
            SUB_SLLI, SUB_SRLI, SUB_ROTRI: begin
              d.legal    = 1'b1;
              d.src2_sel = SRC2_IMM5;
            end
            SUB_SLL, SUB_SRL: begin
              d.legal    = 1'b1;
              d.src2_sel = SRC2_SHAMT;
            end
            default: d.legal = 1'b0;
          endcase
        end
        OP_ADDI, OP_SUBRI: begin
          d.legal    = 1'b1;
          d.arith    = 1'b1;
          d.src2_sel = SRC2_SIMM15;
        end
        OP_ANDI, OP_XORI, OP_ORI: begin
          d.legal    = 1'b1;
          d.src2_sel = SRC2_ZIMM15;
        end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake plus the operand/result bus to the ALU.
interface alu_issue_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic        enable_execute;
  logic [5:0]  opcode;
  logic [4:0]  sub_op_base;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic        alu_overflow;

  // Environment side: instruction source and the ALU itself
  modport master (
    output inst_valid, inst_word, alu_result, alu_overflow,
    input  inst_ready, enable_execute, opcode, sub_op_base, alu_src1, alu_src2
  );

  // Issue unit side
  modport slave (
    input  inst_valid, inst_word, alu_result, alu_overflow,
    output inst_ready, enable_execute, opcode, sub_op_base, alu_src1, alu_src2
  );
endinterface

// File: rtl/alu_issue_rf.sv
// 32x32 register file: one synchronous write port, two combinational operand
// reads and a combinational debug read. Cleared by the async reset, so it maps
// to flops rather than block RAM.
module reg_file_32x32 #(
  parameter int REG_COUNT = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] mem [REG_COUNT];

  // Clear everything on reset; otherwise write one entry when enabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue decode/operand/writeback unit in front of the ALU. One
// instruction every three cycles: IDLE (accept) -> EXEC (ALU busy) -> WB.
module alu_issue #(
  parameter int REG_COUNT = 32
) (
  input  logic        clock,
  input  logic        reset,
  alu_issue_if.slave  bus,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        inst_illegal,
  output logic        overflow_flag,
  input  logic        overflow_clear,
  input  logic [4:0]  rf_dbg_addr,
  output logic [31:0] rf_dbg_data
);
  import alu_issue_pkg::*;

  state_t      state_reg, state_next;
  decode_t     dec;
  logic        load_ops;
  logic        illegal_next;
  logic [31:0] ra_data, rb_data;
  logic [31:0] src2_next;

  logic [5:0]  opcode_reg;
  logic [4:0]  sub_reg;
  logic [31:0] src1_reg, src2_reg;
  logic [4:0]  rt_reg;
  logic        arith_reg;
  logic [4:0]  wb_addr_reg;
  logic [31:0] wb_data_reg;
  logic        illegal_reg;
  logic        overflow_reg;

  assign dec = decode_inst(bus.inst_word);

  // Operands are read straight from the offered word, so a write completed in
  // WB is already visible to the instruction accepted in the following IDLE.
  reg_file_32x32 #(.REG_COUNT(REG_COUNT)) u_rf (
    .clock    (clock),
    .reset    (reset),
    .we       (state_reg == EXEC),
    .waddr    (rt_reg),
    .wdata    (bus.alu_result),
    .raddr_a  (bus.inst_word[19:15]),
    .rdata_a  (ra_data),
    .raddr_b  (bus.inst_word[14:10]),
    .rdata_b  (rb_data),
    .dbg_addr (rf_dbg_addr),
    .dbg_data (rf_dbg_data)
  );

  // Second operand selection according to the decoded instruction form
  always_comb begin
    src2_next = rb_data;
    case (dec.src2_sel)
      SRC2_RB:     src2_next = rb_data;
      SRC2_SHAMT:  src2_next = {27'b0, rb_data[4:0]};
      SRC2_IMM5:   src2_next = {27'b0, bus.inst_word[14:10]};
      SRC2_SIMM15: src2_next = {{17{bus.inst_word[14]}}, bus.inst_word[14:0]};
      SRC2_ZIMM15: src2_next = {17'b0, bus.inst_word[14:0]};
      default:     src2_next = rb_data;
    endcase
  end

  // Next-state and handshake decisions
  always_comb begin
    state_next   = state_reg;
    load_ops     = 1'b0;
    illegal_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.inst_valid) begin
          if (dec.legal) begin
            load_ops   = 1'b1;
            state_next = EXEC;
          end else begin
            illegal_next = 1'b1;
          end
        end
      end
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture ALU operands on accept; they hold outside EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode_reg <= '0;
      sub_reg    <= '0;
      src1_reg   <= '0;
      src2_reg   <= '0;
      rt_reg     <= '0;
      arith_reg  <= 1'b0;
    end else if (load_ops) begin
      opcode_reg <= bus.inst_word[30:25];
      sub_reg    <= bus.inst_word[4:0];
      src1_reg   <= ra_data;
      src2_reg   <= src2_next;
      rt_reg     <= bus.inst_word[24:20];
      arith_reg  <= dec.arith;
    end
  end

  // Latch the writeback report at the end of EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
    end else if (state_reg == EXEC) begin
      wb_addr_reg <= rt_reg;
      wb_data_reg <= bus.alu_result;
    end
  end

  // One-cycle pulse for a dropped word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= illegal_next;
    end
  end

  // Sticky overflow; a set in the same cycle as a clear takes priority
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if ((state_reg == EXEC) && arith_reg && bus.alu_overflow) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clear) begin
      overflow_reg <= 1'b0;
    end
  end

  assign bus.inst_ready     = (state_reg == IDLE);
  assign bus.enable_execute = (state_reg == EXEC);
  assign bus.opcode         = opcode_reg;
  assign bus.sub_op_base    = sub_reg;
  assign bus.alu_src1       = src1_reg;
  assign bus.alu_src2       = src2_reg;
  assign wb_valid           = (state_reg == WB);
  assign wb_addr            = wb_addr_reg;
  assign wb_data            = wb_data_reg;
  assign inst_illegal       = illegal_reg;
  assign overflow_flag      = overflow_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU, vector table with a
// writeback scoreboard, and hand sequences for timing, illegal words,
// overflow set/clear and reset in the middle of an instruction.
module tb_alu_issue;

  localparam logic [5:0] T_TY_BASE = 6'b100000;
  localparam logic [5:0] T_ADDI    = 6'b101000;
  localparam logic [5:0] T_SUBRI   = 6'b101001;
  localparam logic [5:0] T_ANDI    = 6'b101010;
  localparam logic [5:0] T_XORI    = 6'b101011;
  localparam logic [5:0] T_ORI     = 6'b101100;
  localparam logic [5:0] T_LWI     = 6'b000010;
  localparam int NVEC = 20;

  typedef struct packed {
    logic [31:0] word;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        inst_illegal;
  logic        overflow_flag;
  logic        overflow_clear;
  logic [4:0]  rf_dbg_addr;
  logic [31:0] rf_dbg_data;

  int checks = 0;
  int errors = 0;
  wb_t  sb[$];
  vec_t vecs [NVEC];

  alu_issue_if bus ();

  alu_issue dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .inst_illegal   (inst_illegal),
    .overflow_flag  (overflow_flag),
    .overflow_clear (overflow_clear),
    .rf_dbg_addr    (rf_dbg_addr),
    .rf_dbg_data    (rf_dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU driven by the unit's operand bus
  logic [31:0] alu_res;
  logic        alu_ovf;
  logic [31:0] s1, s2;
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    s1 = bus.alu_src1;
    s2 = bus.alu_src2;
    case (bus.opcode)
      T_TY_BASE: begin
        case (bus.sub_op_base)
          5'd0: begin
            alu_res = s1 + s2;
            alu_ovf = (s1[31] == s2[31]) && (alu_res[31] != s1[31]);
          end
          5'd1: begin
            alu_res = s1 - s2;
            alu_ovf = (s1[31] != s2[31]) && (alu_res[31] != s1[31]);
          end
          5'd2:        alu_res = s1 & s2;
          5'd3:        alu_res = s1 ^ s2;
          5'd4:        alu_res = s1 | s2;
          5'd8, 5'd12: alu_res = s1 << s2;
          5'd9, 5'd13: alu_res = s1 >> s2;
          5'd11:       alu_res = (s1 >> s2[4:0]) | (s1 << (6'd32 - {1'b0, s2[4:0]}));
          default:     alu_res = '0;
        endcase
      end
      T_ADDI: begin
        alu_res = s1 + s2;
        alu_ovf = (s1[31] == s2[31]) && (alu_res[31] != s1[31]);
      end
      T_SUBRI: begin
        alu_res = s2 - s1;
        alu_ovf = (s2[31] != s1[31]) && (alu_res[31] != s2[31]);
      end
      T_ANDI:  alu_res = s1 & s2;
      T_XORI:  alu_res = s1 ^ s2;
      T_ORI:   alu_res = s1 | s2;
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_result   = alu_res;
  assign bus.alu_overflow = alu_ovf;

  function automatic logic [31:0] enc_r(input logic [4:0] rt, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [4:0] sub);
    return {1'b0, T_TY_BASE, rt, ra, rb, 5'b0, sub};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] ra, input logic [14:0] imm);
    return {1'b0, op, rt, ra, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every writeback must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got addr %0d data %h expected no writeback", wb_addr, wb_data);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
        chk("wb_data", wb_data, e.data);
        $display("wb r%0d = %h", wb_addr, wb_data);
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clock);
    bus.inst_valid = 1'b1;
    bus.inst_word  = w;
    while (bus.inst_ready !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (bus.inst_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got inst_ready %b expected 1", bus.inst_ready);
    end
    @(posedge clock);
    #1;
    bus.inst_valid = 1'b0;
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wb_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ill [4];
    logic [5:0]  rdy_v, en_v, wbv_v;
    logic [31:0] wa, wbw;

    vecs[0]  = '{32'h50100005, 5'd1, 32'h00000005, 1'b0};
    vecs[1]  = '{32'h50207FFF, 5'd2, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'h40308800, 5'd3, 32'h00000004, 1'b0};
    vecs[3]  = '{32'h50607FFF, 5'd6, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{32'h40630409, 5'd6, 32'h7FFFFFFF, 1'b0};
    vecs[5]  = '{32'h54817FFF, 5'd8, 32'h00007FFF, 1'b0};
    vecs[6]  = '{enc_r(5'd9, 5'd1, 5'd3, 5'd1),   5'd9,  32'h00000001, 1'b0};
    vecs[7]  = '{enc_r(5'd10, 5'd2, 5'd8, 5'd3),  5'd10, 32'hFFFF8000, 1'b0};
    vecs[8]  = '{enc_r(5'd11, 5'd1, 5'd3, 5'd4),  5'd11, 32'h00000005, 1'b0};
    vecs[9]  = '{enc_r(5'd12, 5'd1, 5'd4, 5'd8),  5'd12, 32'h00000050, 1'b0};
    vecs[10] = '{enc_r(5'd13, 5'd1, 5'd2, 5'd12), 5'd13, 32'h80000000, 1'b0};
    vecs[11] = '{enc_r(5'd14, 5'd2, 5'd3, 5'd13), 5'd14, 32'h0FFFFFFF, 1'b0};
    vecs[12] = '{enc_r(5'd15, 5'd8, 5'd4, 5'd11), 5'd15, 32'hF00007FF, 1'b0};
    vecs[13] = '{enc_i(T_SUBRI, 5'd16, 5'd1, 15'h0010), 5'd16, 32'h0000000B, 1'b0};
    vecs[14] = '{enc_i(T_SUBRI, 5'd17, 5'd1, 15'h7FFE), 5'd17, 32'hFFFFFFF9, 1'b0};
    vecs[15] = '{enc_i(T_XORI, 5'd18, 5'd2, 15'h4000),  5'd18, 32'hFFFFBFFF, 1'b0};
    vecs[16] = '{enc_i(T_ORI, 5'd19, 5'd0, 15'h7FF0),   5'd19, 32'h00007FF0, 1'b0};
    vecs[17] = '{enc_i(T_ADDI, 5'd0, 5'd1, 15'h0003),   5'd0,  32'h00000008, 1'b0};
    vecs[18] = '{enc_r(5'd20, 5'd0, 5'd0, 5'd0), 5'd20, 32'h00000010, 1'b0};
    vecs[19] = '{32'h40731800, 5'd7, 32'hFFFFFFFE, 1'b1};

    reset          = 1'b0;
    bus.inst_valid = 1'b0;
    bus.inst_word  = '0;
    overflow_clear = 1'b0;
    rf_dbg_addr    = 5'd0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_inst_ready", {31'b0, bus.inst_ready}, 32'd1);
    chk("rst_enable_execute", {31'b0, bus.enable_execute}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_inst_illegal", {31'b0, inst_illegal}, 32'd0);
    chk("rst_overflow_flag", {31'b0, overflow_flag}, 32'd0);
    chk("rst_opcode", {26'b0, bus.opcode}, 32'd0);
    chk("rst_alu_src1", bus.alu_src1, 32'd0);
    chk("rst_alu_src2", bus.alu_src2, 32'd0);
    chk("rst_rf_dbg", rf_dbg_data, 32'd0);
    reset = 1'b1;

    // Vector table through the scoreboard
    for (int i = 0; i < NVEC; i++) begin
      sb.push_back('{vecs[i].addr, vecs[i].data});
      $display("issue %0d word %h", i, vecs[i].word);
      send(vecs[i].word);
      wait_wb();
      @(negedge clock);
      chk("overflow_flag", {31'b0, overflow_flag}, {31'b0, vecs[i].ovf});
    end

    // Clear pulse drops the sticky flag
    @(negedge clock);
    overflow_clear = 1'b1;
    @(negedge clock);
    overflow_clear = 1'b0;
    chk("overflow_cleared", {31'b0, overflow_flag}, 32'd0);

    // Set and clear in the same cycle: set wins (SUB r21,r6,r2 overflows)
    sb.push_back('{5'd21, 32'h80000000});
    @(negedge clock);
    bus.inst_valid = 1'b1;
    bus.inst_word  = enc_r(5'd21, 5'd6, 5'd2, 5'd1);
    @(posedge clock);
    #1;
    bus.inst_valid = 1'b0;
    @(negedge clock);
    chk("exec_enable", {31'b0, bus.enable_execute}, 32'd1);
    overflow_clear = 1'b1;
    @(negedge clock);
    overflow_clear = 1'b0;
    chk("set_beats_clear", {31'b0, overflow_flag}, 32'd1);
    wait_wb();

    // Debug read port
    rf_dbg_addr = 5'd8;
    #1;
    chk("dbg_r8", rf_dbg_data, 32'h00007FFF);
    rf_dbg_addr = 5'd0;
    #1;
    chk("dbg_r0", rf_dbg_data, 32'h00000008);

    // Illegal words: one-cycle pulse, no ALU cycle, ready again at once
    ill[0] = 32'h80000000;
    ill[1] = enc_i(T_LWI, 5'd1, 5'd2, 15'h0004);
    ill[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd5);
    ill[3] = enc_r(5'd1, 5'd2, 5'd3, 5'd10);
    for (int i = 0; i < 4; i++) begin
      $display("issue illegal word %h", ill[i]);
      @(negedge clock);
      bus.inst_valid = 1'b1;
      bus.inst_word  = ill[i];
      @(negedge clock);
      bus.inst_valid = 1'b0;
      chk("illegal_pulse", {31'b0, inst_illegal}, 32'd1);
      chk("illegal_ready", {31'b0, bus.inst_ready}, 32'd1);
      chk("illegal_no_exec", {31'b0, bus.enable_execute}, 32'd0);
      @(negedge clock);
      chk("illegal_one_cycle", {31'b0, inst_illegal}, 32'd0);
    end
    rf_dbg_addr = 5'd1;
    #1;
    chk("illegal_no_write_r1", rf_dbg_data, 32'h00000005);

    // Back-to-back with valid held: accepts 3 cycles apart, RAW on r22
    wa  = enc_i(T_ADDI, 5'd22, 5'd0, 15'h0007);
    wbw = enc_r(5'd23, 5'd22, 5'd22, 5'd0);
    sb.push_back('{5'd22, 32'h00000008 + 32'h7});
    sb.push_back('{5'd23, 32'h0000001E});
    @(negedge clock);
    bus.inst_valid = 1'b1;
    bus.inst_word  = wa;
    rdy_v = '0;
    en_v  = '0;
    wbv_v = '0;
    rdy_v[0] = bus.inst_ready;
    en_v[0]  = bus.enable_execute;
    wbv_v[0] = wb_valid;
    for (int i = 1; i < 6; i++) begin
      @(negedge clock);
      rdy_v[i] = bus.inst_ready;
      en_v[i]  = bus.enable_execute;
      wbv_v[i] = wb_valid;
      if (i == 1) bus.inst_word = wbw;
      if (i == 4) bus.inst_valid = 1'b0;
    end
    chk("b2b_ready_pattern", {26'b0, rdy_v}, 32'b001001);
    chk("b2b_exec_pattern", {26'b0, en_v}, 32'b010010);
    chk("b2b_wb_pattern", {26'b0, wbv_v}, 32'b100100);
    wait_wb();

    // Reset while ADDI r1,r0,5 is in EXEC: nothing written, back to IDLE
    @(negedge clock);
    bus.inst_valid = 1'b1;
    bus.inst_word  = 32'h50100005;
    @(posedge clock);
    #1;
    bus.inst_valid = 1'b0;
    chk("pre_reset_exec", {31'b0, bus.enable_execute}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, bus.inst_ready}, 32'd1);
    chk("midrst_exec", {31'b0, bus.enable_execute}, 32'd0);
    chk("midrst_src1", bus.alu_src1, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    rf_dbg_addr = 5'd1;
    #1;
    chk("midrst_r1", rf_dbg_data, 32'd0);
    @(negedge clock);
    chk("postrst_ready", {31'b0, bus.inst_ready}, 32'd1);
    chk("postrst_wb_valid", {31'b0, wb_valid}, 32'd0);
    repeat (4) @(negedge clock);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
